// File: rtl/lock_controller.sv
`default_nettype none
// ============================================================================
// Module   : lock_controller
// Brief    : Sequencing FSM for the digital lock: gates keypad digits into the
//            entry shift register, checks the assembled code, drives unlock and
//            alarm, and enforces an attempt limit with timed lockout/relock.
//            Optional feature macro: CODE_PROGRAM_EN (adds set_code input).
// Revision : 1.0 - initial release
// ============================================================================
module lock_controller #(
    parameter int                    CODE_LEN       = 4,
    parameter int                    MAX_ATTEMPTS   = 3,
    parameter int                    UNLOCK_CYCLES  = 500,
    parameter int                    LOCKOUT_CYCLES = 1000,
    parameter logic [CODE_LEN*4-1:0] DEFAULT_CODE   = 16'h1234
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              key_valid,
    input  logic [3:0]                        key_digit,
    input  logic                              submit,
    input  logic                              lock_req,
`ifdef CODE_PROGRAM_EN
    input  logic                              set_code,
`endif
    input  logic [CODE_LEN*4-1:0]             entered_code,
    input  logic                              full,
    output logic                              digit_valid,
    output logic [3:0]                        digit_out,
    output logic                              entry_clr,
    output logic                              unlocked,
    output logic                              alarm,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0] attempts_left,
    output logic                              busy
);

    localparam int CW   = CODE_LEN * 4;
    localparam int AW   = $clog2(MAX_ATTEMPTS + 1);
    localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] C_UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] C_LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [AW-1:0] C_ATTEMPTS_MAX = AW'(MAX_ATTEMPTS);

    localparam logic [2:0] C_S_IDLE     = 3'd0;
    localparam logic [2:0] C_S_ENTRY    = 3'd1;
    localparam logic [2:0] C_S_CHECK    = 3'd2;
    localparam logic [2:0] C_S_FAIL     = 3'd3;
    localparam logic [2:0] C_S_UNLOCKED = 3'd4;
    localparam logic [2:0] C_S_LOCKOUT  = 3'd5;

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nxt;
    logic [AW-1:0] w_attempts_nxt;
    logic [AW-1:0] w_attempts_dec;
    logic          w_gate_state;
    logic          w_accept;
    logic          w_match;
    logic          w_clr_nxt;
    logic [CW-1:0] w_stored_code;

`ifdef CODE_PROGRAM_EN
    logic [CW-1:0] r_stored_code;
    logic          w_load_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stored_code <= DEFAULT_CODE;
        end else if (w_load_code) begin
            r_stored_code <= entered_code;
        end
    end

    assign w_stored_code = r_stored_code;
    // New code digits are typed while open, so the digit gate also opens in UNLOCKED.
    assign w_gate_state  = (r_state == C_S_IDLE) || (r_state == C_S_ENTRY) ||
                           (r_state == C_S_UNLOCKED);
`else
    assign w_stored_code = DEFAULT_CODE;
    assign w_gate_state  = (r_state == C_S_IDLE) || (r_state == C_S_ENTRY);
`endif

    assign w_accept       = key_valid & ~submit & ~full & w_gate_state;
    assign w_match        = full && (entered_code == w_stored_code);
    assign w_attempts_dec = (attempts_left != '0) ? (attempts_left - AW'(1)) : '0;

    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer;
        w_attempts_nxt = attempts_left;
        w_clr_nxt      = 1'b0;
`ifdef CODE_PROGRAM_EN
        w_load_code    = 1'b0;
`endif
        case (r_state)
            C_S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = C_S_ENTRY;
                end
            end
            C_S_ENTRY: begin
                if (submit) begin
                    w_state_nxt = C_S_CHECK;
                end
            end
            C_S_CHECK: begin
                w_clr_nxt = 1'b1;
                if (w_match) begin
                    w_state_nxt    = C_S_UNLOCKED;
                    w_timer_nxt    = C_UNLOCK_LOAD;
                    w_attempts_nxt = C_ATTEMPTS_MAX;
                end else begin
                    w_attempts_nxt = w_attempts_dec;
                    if (w_attempts_dec == '0) begin
                        w_state_nxt = C_S_LOCKOUT;
                        w_timer_nxt = C_LOCKOUT_LOAD;
                    end else begin
                        w_state_nxt = C_S_FAIL;
                    end
                end
            end
            C_S_FAIL: begin
                w_state_nxt = C_S_IDLE;
            end
            C_S_UNLOCKED: begin
                // An explicit relock wins over reprogramming and over expiry.
                if (lock_req) begin
                    w_state_nxt = C_S_IDLE;
                    w_timer_nxt = '0;
`ifdef CODE_PROGRAM_EN
                end else if (set_code && full) begin
                    w_load_code = 1'b1;
                    w_clr_nxt   = 1'b1;
                    w_timer_nxt = C_UNLOCK_LOAD;
`endif
                end else if (r_timer == '0) begin
                    w_state_nxt = C_S_IDLE;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            C_S_LOCKOUT: begin
                if (r_timer == '0) begin
                    w_state_nxt    = C_S_IDLE;
                    w_attempts_nxt = C_ATTEMPTS_MAX;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            default: begin
                w_state_nxt = C_S_IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= C_S_IDLE;
            r_timer       <= '0;
            attempts_left <= C_ATTEMPTS_MAX;
            digit_valid   <= 1'b0;
            digit_out     <= 4'd0;
            entry_clr     <= 1'b0;
            unlocked      <= 1'b0;
            alarm         <= 1'b0;
            busy          <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            attempts_left <= w_attempts_nxt;
            digit_valid   <= w_accept;
            if (w_accept) begin
                digit_out <= key_digit;
            end
            entry_clr     <= w_clr_nxt;
            unlocked      <= (w_state_nxt == C_S_UNLOCKED);
            alarm         <= (w_state_nxt == C_S_LOCKOUT);
            busy          <= (w_state_nxt == C_S_CHECK)    || (w_state_nxt == C_S_FAIL) ||
                             (w_state_nxt == C_S_UNLOCKED) || (w_state_nxt == C_S_LOCKOUT);
        end
    end

endmodule
`default_nettype wire
